// File: rtl/multi_plane_controller_pkg.sv
// Shared game-state encodings, default scan codes and counter-width helper
// for the multi-plane controller.
package multi_plane_controller_pkg;

    typedef enum logic [1:0] {
        PRESS_START = 2'd0,
        PLAYING     = 2'd1,
        GAMEOVER    = 2'd2,
        RESTART     = 2'd3
    } game_state_e;

    localparam int unsigned SCAN_W = 9;
    localparam int unsigned KEYS_W = 512;

    // Plane 0: A/D/W, plane 1: J/L/I
    localparam logic [SCAN_W-1:0] SC_A = 9'h1C;
    localparam logic [SCAN_W-1:0] SC_D = 9'h23;
    localparam logic [SCAN_W-1:0] SC_W = 9'h1D;
    localparam logic [SCAN_W-1:0] SC_J = 9'h3B;
    localparam logic [SCAN_W-1:0] SC_L = 9'h4B;
    localparam logic [SCAN_W-1:0] SC_I = 9'h43;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/multi_plane_controller_plane_channel.sv
// One plane's datapath: bounded movement, fire-edge detection and laser
// cooldown, all outputs registered.
module plane_channel
    import multi_plane_controller_pkg::*;
#(
    parameter int unsigned POS_W    = 10,
    parameter int unsigned INIT     = 145,
    parameter int unsigned LIMIT_L  = 40,
    parameter int unsigned LIMIT_R  = 250,
    parameter int unsigned STEP     = 1,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_init,
    input  logic              playing,
    input  logic              tick,
    input  logic [KEYS_W-1:0] key_down,
    input  logic [SCAN_W-1:0] code_l,
    input  logic [SCAN_W-1:0] code_r,
    input  logic [SCAN_W-1:0] code_fire,
    output logic [POS_W-1:0]  pos,
    output logic              laser_attack,
    output logic              laser_ready
);

    localparam int unsigned EW   = POS_W + 1;
    localparam int unsigned CD_W = cnt_w(COOLDOWN);

    logic            key_l, key_r, key_fire, fire_prev, fire_edge;
    logic [CD_W-1:0] cd, cd_n;
    logic [POS_W-1:0] pos_n;
    logic [EW-1:0]   pos_ext, sum_r;
    logic            atk_n;

    assign key_l     = key_down[code_l];
    assign key_r     = key_down[code_r];
    assign key_fire  = key_down[code_fire];
    assign fire_edge = key_fire & ~fire_prev;
    assign pos_ext   = {1'b0, pos};
    assign sum_r     = pos_ext + EW'(STEP);

    // Next position, cooldown and pulse; init states override play/gameover
    always_comb begin
        pos_n = pos;
        cd_n  = (cd != '0) ? cd - CD_W'(1) : cd;
        atk_n = 1'b0;
        if (load_init) begin
            pos_n = POS_W'(INIT);
            cd_n  = '0;
        end else if (playing) begin
            if (tick) begin
                case ({key_l, key_r})
                    2'b10: pos_n = (pos_ext >= EW'(LIMIT_L) + EW'(STEP)) ?
                                   pos - POS_W'(STEP) : POS_W'(LIMIT_L);
                    2'b01: pos_n = (sum_r > EW'(LIMIT_R)) ?
                                   POS_W'(LIMIT_R) : sum_r[POS_W-1:0];
                    default: pos_n = pos;
                endcase
            end
            if (fire_edge && cd == '0) begin
                atk_n = 1'b1;
                cd_n  = CD_W'(COOLDOWN);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos          <= POS_W'(INIT);
            cd           <= '0;
            fire_prev    <= 1'b0;
            laser_attack <= 1'b0;
            laser_ready  <= 1'b1;
        end else begin
            pos          <= pos_n;
            cd           <= cd_n;
            fire_prev    <= key_fire;
            laser_attack <= atk_n;
            laser_ready  <= (cd_n == '0);
        end
    end

endmodule

// File: rtl/multi_plane_controller.sv
// Multi-plane controller top: decodes game state, runs the shared move
// prescaler and instantiates one plane_channel per plane.
module multi_plane_controller
    import multi_plane_controller_pkg::*;
#(
    parameter int unsigned N_PLANES     = 2,
    parameter int unsigned POS_W        = 10,
    parameter int unsigned INIT_POS     = 145,
    parameter int unsigned INIT_SPACING = 40,
    parameter int unsigned LIMIT_L      = 40,
    parameter int unsigned LIMIT_R      = 250,
    parameter int unsigned STEP         = 1,
    parameter int unsigned MOVE_DIV     = 1,
    parameter int unsigned COOLDOWN     = 8,
    parameter logic [N_PLANES*SCAN_W-1:0] KEY_L    = {SC_J, SC_A},
    parameter logic [N_PLANES*SCAN_W-1:0] KEY_R    = {SC_L, SC_D},
    parameter logic [N_PLANES*SCAN_W-1:0] KEY_FIRE = {SC_I, SC_W}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                state,
    input  logic [KEYS_W-1:0]         key_down,
    output logic [N_PLANES*POS_W-1:0] plane_h,
    output logic [N_PLANES-1:0]       laser_attack,
    output logic [N_PLANES-1:0]       laser_ready
);

    localparam int unsigned PS_W = cnt_w(MOVE_DIV - 1);

    game_state_e     gs;
    logic            playing, load_init, tick;
    logic [PS_W-1:0] ps, ps_n;

    assign gs = game_state_e'(state);

    // State decode and free-running move prescaler
    always_comb begin
        playing   = (gs == PLAYING);
        load_init = (gs == PRESS_START) || (gs == RESTART);
        tick      = playing && (ps == PS_W'(MOVE_DIV - 1));
        ps_n      = ps;
        if (load_init) begin
            ps_n = '0;
        end else if (playing) begin
            ps_n = tick ? '0 : ps + PS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps <= '0;
        end else begin
            ps <= ps_n;
        end
    end

    for (genvar i = 0; i < int'(N_PLANES); i++) begin : g_plane
        plane_channel #(
            .POS_W    (POS_W),
            .INIT     (INIT_POS + 32'(i) * INIT_SPACING),
            .LIMIT_L  (LIMIT_L),
            .LIMIT_R  (LIMIT_R),
            .STEP     (STEP),
            .COOLDOWN (COOLDOWN)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .load_init    (load_init),
            .playing      (playing),
            .tick         (tick),
            .key_down     (key_down),
            .code_l       (KEY_L[i*SCAN_W +: SCAN_W]),
            .code_r       (KEY_R[i*SCAN_W +: SCAN_W]),
            .code_fire    (KEY_FIRE[i*SCAN_W +: SCAN_W]),
            .pos          (plane_h[i*POS_W +: POS_W]),
            .laser_attack (laser_attack[i]),
            .laser_ready  (laser_ready[i])
        );
    end

endmodule

// File: tb/tb_multi_plane_controller.sv
// Directed + randomized bench for multi_plane_controller with a cycle-level
// game model built from the plane rules (positions, cooldowns, fire edges).
module tb_multi_plane_controller;

    localparam int MOVE_DIV = 4;
    localparam int COOLDOWN = 8;
    localparam int LIM_L    = 40;
    localparam int LIM_R    = 250;
    localparam int KL [2] = '{28, 59};   // A, J
    localparam int KR [2] = '{35, 75};   // D, L
    localparam int KF [2] = '{29, 67};   // W, I

    logic         clk;
    logic         rst;
    logic [1:0]   state;
    logic [511:0] key_down;
    logic [19:0]  plane_h;
    logic [1:0]   laser_attack;
    logic [1:0]   laser_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_pos [2];
    int m_cd  [2];
    bit m_prev[2];
    bit m_atk [2];
    bit m_rdy [2];
    int m_ps;

    multi_plane_controller #(
        .N_PLANES (2),
        .MOVE_DIV (MOVE_DIV),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .key_down     (key_down),
        .plane_h      (plane_h),
        .laser_attack (laser_attack),
        .laser_ready  (laser_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]  = 145 + 40 * i;
            m_cd[i]   = 0;
            m_prev[i] = 1'b0;
            m_atk[i]  = 1'b0;
            m_rdy[i]  = 1'b1;
        end
        m_ps = 0;
    endtask

    task automatic set_keys(input bit l0, r0, f0, l1, r1, f1);
        key_down = '0;
        key_down[KL[0]] = l0; key_down[KR[0]] = r0; key_down[KF[0]] = f0;
        key_down[KL[1]] = l1; key_down[KR[1]] = r1; key_down[KF[1]] = f1;
    endtask

    task automatic model_cycle();
        bit tick, l, r, f, edge_seen;
        int st, ncd;
        st = int'(state);
        if (rst) begin
            model_reset();
            return;
        end
        tick = (st == 1) && (m_ps == MOVE_DIV - 1);
        if (st == 0 || st == 3) m_ps = 0;
        else if (st == 1)       m_ps = (m_ps + 1) % MOVE_DIV;
        for (int i = 0; i < 2; i++) begin
            l = key_down[KL[i]]; r = key_down[KR[i]]; f = key_down[KF[i]];
            edge_seen = f && !m_prev[i];
            m_prev[i] = f;
            m_atk[i]  = 1'b0;
            if (st == 0 || st == 3) begin
                m_pos[i] = 145 + 40 * i;
                m_cd[i]  = 0;
            end else begin
                ncd = (m_cd[i] > 0) ? m_cd[i] - 1 : 0;
                if (st == 1) begin
                    if (tick && l && !r) m_pos[i] = (m_pos[i] - 1 < LIM_L) ? LIM_L : m_pos[i] - 1;
                    if (tick && r && !l) m_pos[i] = (m_pos[i] + 1 > LIM_R) ? LIM_R : m_pos[i] + 1;
                    if (edge_seen && m_cd[i] == 0) begin
                        m_atk[i] = 1'b1;
                        ncd = COOLDOWN;
                    end
                end
                m_cd[i] = ncd;
            end
            m_rdy[i] = (m_cd[i] == 0);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_h0"}, 32'(plane_h[9:0]), 32'(m_pos[0]));
        check({tag, "_h1"}, 32'(plane_h[19:10]), 32'(m_pos[1]));
        check({tag, "_atk"}, 32'(laser_attack), {30'd0, m_atk[1], m_atk[0]});
        check({tag, "_rdy"}, 32'(laser_ready), {30'd0, m_rdy[1], m_rdy[0]});
    endtask

    // One clock: model advances on the inputs in place before the edge
    task automatic step(input string tag);
        @(posedge clk);
        model_cycle();
        #1;
        compare_model(tag);
    endtask

    initial begin
        int pulses, guard;
        bit move_left;
        rst = 1'b0; state = 2'd0; key_down = '0;
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_h", 32'(plane_h), 32'({10'd185, 10'd145}));
        check("rst_rdy", 32'(laser_ready), 32'd3);
        check("rst_atk", 32'(laser_attack), 32'd0);
        step("rst");
        step("rst");
        rst = 1'b0;
        step("idle");
        check("s0_h", 32'(plane_h), 32'({10'd185, 10'd145}));
        check("s0_rdy", 32'(laser_ready), 32'd3);

        // Hold A for 40 playing cycles
        state = 2'd1;
        set_keys(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 40; c++) step("holdA");
        check("holdA40_p0", 32'(plane_h[9:0]), 32'd135);
        check("holdA40_p1", 32'(plane_h[19:10]), 32'd185);

        // Drive into the left limit, then both keys together
        for (int c = 0; c < 500; c++) step("limitL");
        check("limitL_p0", 32'(plane_h[9:0]), 32'd40);
        set_keys(1, 1, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) step("bothLR");
        check("bothLR_p0", 32'(plane_h[9:0]), 32'd40);

        // Tap W at cycles 0, 3, 10
        for (int c = 0; c <= 12; c++) begin
            set_keys(0, 0, (c == 0 || c == 3 || c == 10), 0, 0, 0);
            step("tap");
            check("tap_atk", 32'(laser_attack[0]), 32'((c + 1 == 1) || (c + 1 == 11)));
            check("tap_rdy", 32'(laser_ready[0]), 32'(!((c + 1 >= 1 && c + 1 <= 8) || c + 1 >= 11)));
        end
        set_keys(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 12; c++) step("settle");

        // Held fire key gives a single pulse
        pulses = 0;
        set_keys(0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 30; c++) begin
            step("holdW");
            pulses += int'(laser_attack[0]);
        end
        check("holdW_pulses", 32'(pulses), 32'd1);
        set_keys(0, 0, 0, 0, 0, 0);
        step("rel");

        // Randomized play across both planes and all states
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 11))
                0:       state = 2'd0;
                1:       state = 2'd2;
                2:       state = 2'd3;
                default: state = 2'd1;
            endcase
            set_keys($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                     $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
            step("rand");
        end

        // Bring plane 0 to 60, start a cooldown, then reset asynchronously
        state = 2'd1;
        move_left = (m_pos[0] > 60);
        set_keys(move_left, !move_left, 0, 0, 0, 0);
        guard = 0;
        while (m_pos[0] != 60 && guard < 1000) begin
            step("to60");
            guard++;
        end
        check("to60_p0", 32'(plane_h[9:0]), 32'd60);
        set_keys(0, 0, 1, 0, 0, 0);
        step("fire60");
        check("fire60_atk", 32'(laser_attack[0]), 32'd1);
        set_keys(0, 0, 0, 0, 0, 0);
        step("cool");
        step("cool");
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst_h", 32'(plane_h), 32'({10'd185, 10'd145}));
        check("midrst_rdy", 32'(laser_ready), 32'd3);
        check("midrst_atk", 32'(laser_attack), 32'd0);
        step("rst2");
        rst = 1'b0;

        // Gameover: keys held, nothing moves or fires
        state = 2'd2;
        set_keys(1, 0, 1, 0, 1, 1);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step("gameover");
            pulses += int'(laser_attack[0]) + int'(laser_attack[1]);
        end
        check("go_h", 32'(plane_h), 32'({10'd185, 10'd145}));
        check("go_pulses", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
